// File: rtl/board_m_if.sv
// rtl/board_m_if.sv - move request / board status bundle between mover and board_m
interface board_m_if;
    logic [3:0]  update_loc;
    logic [1:0]  update_val;
    logic        submit;
    logic        turn;
    logic [17:0] board_state;
    logic        move_ack;
    logic        move_nak;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output update_loc, update_val, submit,
        input  turn, board_state, move_ack, move_nak, game_over, winner
    );

    modport slave (
        input  update_loc, update_val, submit,
        output turn, board_state, move_ack, move_nak, game_over, winner
    );
endinterface

// File: rtl/board_m.sv
// rtl/board_m.sv - 3x3 board keeper: move validation, win/draw detection, turn tracking
// Optional BOARD_MARK_CHECK_EN: only X on the player turn and O on the AI turn are legal.
module board_m (
    input  logic       clk,
    input  logic       reset,
    board_m_if.slave   bus
);
    localparam logic [1:0] CELL_EMPTY  = 2'd0;
    localparam logic [1:0] CELL_X      = 2'd1;
    localparam logic [1:0] CELL_O      = 2'd2;
    localparam logic       TURN_PLAYER = 1'b0;
    localparam logic       TURN_AI     = 1'b1;

    // Cell indices of the 8 lines: 3 rows, 3 columns, 2 diagonals
    localparam int LA [8] = '{0, 3, 6, 0, 1, 2, 0, 2};
    localparam int LB [8] = '{1, 4, 7, 3, 4, 5, 4, 4};
    localparam int LC [8] = '{2, 5, 8, 6, 7, 8, 8, 6};

    typedef enum logic [1:0] {S_WAIT, S_WRITE, S_CHECK, S_DONE} state_t;

    state_t      state;
    logic        submit_q;
    logic [3:0]  cap_loc;
    logic [1:0]  cap_val;
    logic [17:0] board;
    logic        turn;
    logic [3:0]  move_count;
    logic        move_ack;
    logic        move_nak;
    logic        nak_pending;
    logic        game_over;
    logic [1:0]  winner;

    logic        rise;
    logic [1:0]  cur_cell;
    logic        mark_ok;
    logic        legal;
    logic        line_hit;
    logic [1:0]  line_mark;

    assign rise = bus.submit & ~submit_q;

    always_comb begin
        cur_cell = CELL_EMPTY;
        for (int i = 0; i < 9; i++) begin
            if (cap_loc == 4'(i)) cur_cell = board[2*i +: 2];
        end
    end

`ifdef BOARD_MARK_CHECK_EN
    assign mark_ok = (turn == TURN_PLAYER) ? (cap_val == CELL_X) : (cap_val == CELL_O);
`else
    assign mark_ok = 1'b1;
`endif

    assign legal = (cap_loc <= 4'd8) && (cur_cell == CELL_EMPTY) &&
                   (cap_val != CELL_EMPTY) && mark_ok;

    always_comb begin
        line_hit  = 1'b0;
        line_mark = CELL_EMPTY;
        for (int l = 0; l < 8; l++) begin
            if (board[2*LA[l] +: 2] != CELL_EMPTY &&
                board[2*LA[l] +: 2] == board[2*LB[l] +: 2] &&
                board[2*LA[l] +: 2] == board[2*LC[l] +: 2]) begin
                line_hit  = 1'b1;
                line_mark = board[2*LA[l] +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_WAIT;
            submit_q    <= 1'b0;
            cap_loc     <= 4'd0;
            cap_val     <= CELL_EMPTY;
            board       <= '0;
            turn        <= TURN_PLAYER;
            move_count  <= 4'd0;
            move_ack    <= 1'b0;
            move_nak    <= 1'b0;
            nak_pending <= 1'b0;
            game_over   <= 1'b0;
            winner      <= CELL_EMPTY;
        end else begin
            submit_q    <= bus.submit;
            move_ack    <= 1'b0;
            move_nak    <= 1'b0;
            nak_pending <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (rise) begin
                        cap_loc <= bus.update_loc;
                        cap_val <= bus.update_val;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (legal) begin
                        for (int i = 0; i < 9; i++) begin
                            if (cap_loc == 4'(i)) board[2*i +: 2] <= cap_val;
                        end
                        move_count <= move_count + 4'd1;
                        move_ack   <= 1'b1;
                        state      <= S_CHECK;
                    end else begin
                        move_nak <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_CHECK: begin
                    // turn only changes here, keeping it stable for downstream drivers
                    if (line_hit) begin
                        winner    <= line_mark;
                        game_over <= 1'b1;
                        state     <= S_DONE;
                    end else if (move_count == 4'd9) begin
                        winner    <= CELL_EMPTY;
                        game_over <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        turn  <= (turn == TURN_PLAYER) ? TURN_AI : TURN_PLAYER;
                        state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    // nak lands with the same latency as a rejected move in WRITE
                    if (rise) nak_pending <= 1'b1;
                    move_nak <= nak_pending;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign bus.turn        = turn;
    assign bus.board_state = board;
    assign bus.move_ack    = move_ack;
    assign bus.move_nak    = move_nak;
    assign bus.game_over   = game_over;
    assign bus.winner      = winner;
endmodule

// File: tb/tb_board_m.sv
// tb/tb_board_m.sv - directed self-checking bench for board_m
module tb_board_m;
    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    board_m_if bus();

    board_m dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] X = 2'd1;
    localparam logic [1:0] O = 2'd2;

    localparam int         ROW_LOC  [5] = '{0, 3, 1, 4, 2};
    localparam logic [1:0] ROW_VAL  [5] = '{X, O, X, O, X};
    localparam logic       ROW_TURN [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam int         DRAW_LOC [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    localparam int         DIAG_LOC [6] = '{0, 2, 1, 4, 3, 6};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic [3:0] loc, input logic [1:0] val,
                           output logic ack, output logic nak);
        bus.update_loc = loc;
        bus.update_val = val;
        bus.submit     = 1'b1;
        tick();
        bus.submit = 1'b0;
        tick();
        ack = bus.move_ack;
        nak = bus.move_nak;
        tick();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.submit = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.update_loc = 4'd0;
        bus.update_val = 2'd0;
        apply_reset();
        tests_run += 6;
        if (bus.board_state !== 18'h0) begin tests_failed++; $display("FAIL reset_board got %h want 0", bus.board_state); end
        if (bus.turn !== 1'b0)         begin tests_failed++; $display("FAIL reset_turn got %b want 0", bus.turn); end
        if (bus.game_over !== 1'b0)    begin tests_failed++; $display("FAIL reset_over got %b want 0", bus.game_over); end
        if (bus.winner !== 2'd0)       begin tests_failed++; $display("FAIL reset_winner got %0d want 0", bus.winner); end
        if (bus.move_ack !== 1'b0)     begin tests_failed++; $display("FAIL reset_ack got %b want 0", bus.move_ack); end
        if (bus.move_nak !== 1'b0)     begin tests_failed++; $display("FAIL reset_nak got %b want 0", bus.move_nak); end
    endtask

    task automatic test_row_win();
        logic ack, nak;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_move(4'(ROW_LOC[i]), ROW_VAL[i], ack, nak);
            tests_run += 2;
            if (ack !== 1'b1 || nak !== 1'b0) begin tests_failed++; $display("FAIL row_ack%0d got ack=%b nak=%b want ack=1 nak=0", i, ack, nak); end
            if (bus.turn !== ROW_TURN[i]) begin tests_failed++; $display("FAIL row_turn%0d got %b want %b", i, bus.turn, ROW_TURN[i]); end
        end
        tests_run += 3;
        if (bus.game_over !== 1'b1)      begin tests_failed++; $display("FAIL row_over got %b want 1", bus.game_over); end
        if (bus.winner !== X)            begin tests_failed++; $display("FAIL row_winner got %0d want 1", bus.winner); end
        if (bus.board_state !== 18'h00295) begin tests_failed++; $display("FAIL row_board got %h want 00295", bus.board_state); end
    endtask

    task automatic test_diag_o_win();
        logic ack, nak;
        int acks = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            do_move(4'(DIAG_LOC[i]), (i % 2 == 0) ? X : O, ack, nak);
            acks += int'(ack);
        end
        tests_run += 4;
        if (acks !== 6)             begin tests_failed++; $display("FAIL diag_acks got %0d want 6", acks); end
        if (bus.game_over !== 1'b1) begin tests_failed++; $display("FAIL diag_over got %b want 1", bus.game_over); end
        if (bus.winner !== O)       begin tests_failed++; $display("FAIL diag_winner got %0d want 2", bus.winner); end
        if (bus.turn !== 1'b1)      begin tests_failed++; $display("FAIL diag_turn got %b want 1", bus.turn); end
    endtask

    task automatic test_occupied();
        logic ack, nak;
        apply_reset();
        do_move(4'd4, X, ack, nak);
        tests_run += 4;
        if (ack !== 1'b1)      begin tests_failed++; $display("FAIL occ_first_ack got %b want 1", ack); end
        do_move(4'd4, O, ack, nak);
        if (ack !== 1'b0 || nak !== 1'b1) begin tests_failed++; $display("FAIL occ_nak got ack=%b nak=%b want ack=0 nak=1", ack, nak); end
        if (bus.board_state[9:8] !== X) begin tests_failed++; $display("FAIL occ_cell4 got %0d want 1", bus.board_state[9:8]); end
        if (bus.turn !== 1'b1) begin tests_failed++; $display("FAIL occ_turn got %b want 1", bus.turn); end
    endtask

    task automatic test_range_and_hold();
        logic ack, nak;
        int acks = 0;
        int naks = 0;
        apply_reset();
        tests_run += 6;
        do_move(4'd9, X, ack, nak);
        if (nak !== 1'b1 || ack !== 1'b0) begin tests_failed++; $display("FAIL loc9 got ack=%b nak=%b want ack=0 nak=1", ack, nak); end
        do_move(4'd15, X, ack, nak);
        if (nak !== 1'b1 || ack !== 1'b0) begin tests_failed++; $display("FAIL loc15 got ack=%b nak=%b want ack=0 nak=1", ack, nak); end
        do_move(4'd0, 2'd0, ack, nak);
        if (nak !== 1'b1 || ack !== 1'b0) begin tests_failed++; $display("FAIL empty_val got ack=%b nak=%b want ack=0 nak=1", ack, nak); end
        if (bus.board_state !== 18'h0) begin tests_failed++; $display("FAIL range_board got %h want 0", bus.board_state); end
        bus.update_loc = 4'd0;
        bus.update_val = X;
        bus.submit     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            acks += int'(bus.move_ack);
            naks += int'(bus.move_nak);
        end
        bus.submit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            acks += int'(bus.move_ack);
            naks += int'(bus.move_nak);
        end
        if (acks !== 1 || naks !== 0) begin tests_failed++; $display("FAIL hold got acks=%0d naks=%0d want 1 and 0", acks, naks); end
        if (bus.board_state !== 18'h00001) begin tests_failed++; $display("FAIL hold_board got %h want 00001", bus.board_state); end
    endtask

    task automatic test_draw();
        logic ack, nak;
        int acks = 0;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_move(4'(DRAW_LOC[i]), (i % 2 == 0) ? X : O, ack, nak);
            acks += int'(ack);
        end
        tests_run += 7;
        if (acks !== 9)                    begin tests_failed++; $display("FAIL draw_acks got %0d want 9", acks); end
        if (bus.game_over !== 1'b1)        begin tests_failed++; $display("FAIL draw_over got %b want 1", bus.game_over); end
        if (bus.winner !== 2'd0)           begin tests_failed++; $display("FAIL draw_winner got %0d want 0", bus.winner); end
        if (bus.turn !== 1'b0)             begin tests_failed++; $display("FAIL draw_turn got %b want 0", bus.turn); end
        if (bus.board_state !== 18'h16A59) begin tests_failed++; $display("FAIL draw_board got %h want 16a59", bus.board_state); end
        do_move(4'd0, O, ack, nak);
        if (nak !== 1'b1 || ack !== 1'b0)  begin tests_failed++; $display("FAIL done_nak got ack=%b nak=%b want ack=0 nak=1", ack, nak); end
        if (bus.board_state !== 18'h16A59) begin tests_failed++; $display("FAIL done_board got %h want 16a59", bus.board_state); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        apply_reset();
        bus.update_loc = 4'd4;
        bus.update_val = X;
        bus.submit     = 1'b1;
        tick();
        reset      = 1'b1;
        bus.submit = 1'b0;
        tick();
        reset = 1'b0;
        tests_run += 5;
        if (bus.move_ack !== 1'b0) begin tests_failed++; $display("FAIL mid_ack got %b want 0", bus.move_ack); end
        for (int c = 0; c < 4; c++) begin
            tick();
            pulses += int'(bus.move_ack) + int'(bus.move_nak);
        end
        if (pulses !== 0)              begin tests_failed++; $display("FAIL mid_stale got %0d pulses want 0", pulses); end
        if (bus.board_state !== 18'h0) begin tests_failed++; $display("FAIL mid_board got %h want 0", bus.board_state); end
        if (bus.turn !== 1'b0)         begin tests_failed++; $display("FAIL mid_turn got %b want 0", bus.turn); end
        reset      = 1'b1;
        bus.submit = 1'b1;
        tick();
        reset      = 1'b0;
        bus.submit = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            pulses += int'(bus.move_ack) + int'(bus.move_nak);
        end
        if (pulses !== 0 || bus.board_state !== 18'h0) begin tests_failed++; $display("FAIL same_cycle got pulses=%0d board=%h want 0 and 0", pulses, bus.board_state); end
    endtask

    task automatic test_mark();
        logic ack, nak;
        apply_reset();
        do_move(4'd0, O, ack, nak);
        tests_run += 2;
`ifdef BOARD_MARK_CHECK_EN
        if (ack !== 1'b0 || nak !== 1'b1) begin tests_failed++; $display("FAIL mark_resp got ack=%b nak=%b want ack=0 nak=1", ack, nak); end
        if (bus.board_state !== 18'h0)    begin tests_failed++; $display("FAIL mark_board got %h want 0", bus.board_state); end
`else
        if (ack !== 1'b1 || nak !== 1'b0) begin tests_failed++; $display("FAIL mark_resp got ack=%b nak=%b want ack=1 nak=0", ack, nak); end
        if (bus.board_state[1:0] !== O)   begin tests_failed++; $display("FAIL mark_cell got %0d want 2", bus.board_state[1:0]); end
`endif
    endtask

    initial begin
        reset          = 1'b1;
        bus.submit     = 1'b0;
        bus.update_loc = 4'd0;
        bus.update_val = 2'd0;
        #2;
        test_reset();
        test_row_win();
        test_diag_o_win();
        test_occupied();
        test_range_and_hold();
        test_draw();
        test_reset_mid();
        test_mark();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1);
    end
endmodule
